// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: syncs PLL lock, stages core/video reset release, makes the CPU/VDC tick and tracks lock losses
module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int RELEASE_GAP   = 16,
  parameter int CE_DIV        = 15,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  input  logic             soft_reset,
  output logic             rst_core,
  output logic             rst_video,
  output logic             ready,
  output logic             clk_en,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_cnt
);
  localparam int CW = $clog2((STABLE_CYCLES > RELEASE_GAP ? STABLE_CYCLES : RELEASE_GAP) + 1);
  localparam int DW = $clog2(CE_DIV + 1);
  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, GAP, RUN} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic locked_s, clk_en_n, lost_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] div, div_n;
  logic [CNT_W-1:0] loss_n;
  assign locked_s = sync[SYNC_STAGES-1];
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    div_n    = div;
    clk_en_n = 1'b0;
    lost_n   = lock_lost;
    loss_n   = loss_cnt;
    case (state)
      WAIT_LOCK: begin
        cnt_n   = '0;
        state_n = locked_s ? SETTLE : WAIT_LOCK;
      end
      SETTLE: begin
        cnt_n   = (!locked_s || cnt == CW'(STABLE_CYCLES - 1)) ? '0 : cnt + CW'(1);
        state_n = !locked_s ? WAIT_LOCK : cnt == CW'(STABLE_CYCLES - 1) ? GAP : SETTLE;
      end
      GAP: begin
        cnt_n   = (!locked_s || cnt == CW'(RELEASE_GAP - 1)) ? '0 : cnt + CW'(1);
        state_n = !locked_s ? WAIT_LOCK : cnt == CW'(RELEASE_GAP - 1) ? RUN : GAP;
        div_n   = '0;
      end
      default: begin
        // lock loss outranks a simultaneous soft reset so it is always counted
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          lost_n  = 1'b1;
          loss_n  = &loss_cnt ? loss_cnt : loss_cnt + CNT_W'(1);
        end else if (soft_reset) begin
          state_n = SETTLE;
          cnt_n   = '0;
        end else begin
          clk_en_n = div == DW'(CE_DIV - 1);
          div_n    = clk_en_n ? '0 : div + DW'(1);
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= '0;
      state     <= WAIT_LOCK;
      cnt       <= '0;
      div       <= '0;
      rst_core  <= 1'b1;
      rst_video <= 1'b1;
      ready     <= 1'b0;
      clk_en    <= 1'b0;
      lock_lost <= 1'b0;
      loss_cnt  <= '0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], locked};
      state     <= state_n;
      cnt       <= cnt_n;
      div       <= div_n;
      rst_core  <= state_n == WAIT_LOCK || state_n == SETTLE;
      rst_video <= state_n != RUN;
      ready     <= state_n == RUN;
      clk_en    <= clk_en_n;
      lock_lost <= lost_n;
      loss_cnt  <= loss_n;
    end
  end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: release timing, lock loss, soft reset and saturation against a release-age model
module tb_pll_reset_sequencer;
  localparam int SY = 2, S = 8, G = 4, C = 3, W = 2;
  localparam int R = S + G + 1;
  logic clk = 0, rst = 1, locked = 0, soft_reset = 0;
  logic rst_core, rst_video, ready, clk_en, lock_lost;
  logic [W-1:0] loss_cnt;
  int errs = 0, checks = 0;
  int k = 0, loss = 0;
  bit lost = 0;
  bit [SY-1:0] hist = '0;

  pll_reset_sequencer #(.SYNC_STAGES(SY), .STABLE_CYCLES(S), .RELEASE_GAP(G), .CE_DIV(C), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .locked(locked), .soft_reset(soft_reset), .rst_core(rst_core),
    .rst_video(rst_video), .ready(ready), .clk_en(clk_en), .lock_lost(lock_lost), .loss_cnt(loss_cnt));

  always #5 clk = ~clk;

  // k = cycles since the release sequence began (0 = waiting for lock)
  function automatic logic [6:0] exp_v();
    logic [W-1:0] l = W'(loss);
    return {k < S + 1, k < R, k >= R, k > R && (k - R) % C == 0, lost, l};
  endfunction

  function automatic logic [6:0] obs();
    return {rst_core, rst_video, ready, clk_en, lock_lost, loss_cnt};
  endfunction

  task automatic step(input logic l, input logic s);
    bit ls;
    locked = l;
    soft_reset = s;
    @(posedge clk);
    ls = hist[SY-1];
    hist = {hist[SY-2:0], l};
    if (k == 0) k = ls ? 1 : 0;
    else if (!ls) begin
      if (k >= R) begin
        lost = 1;
        if (loss < (1 << W) - 1) loss++;
      end
      k = 0;
    end else if (s && k >= R) k = 1;
    else k++;
    #1;
  endtask

  task automatic do_reset();
    locked = 0;
    soft_reset = 0;
    rst = 1;
    k = 0; loss = 0; lost = 0; hist = '0;
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs() !== 7'b1100000) begin errs++; $display("FAIL reset_vals got=%b exp=%b", obs(), 7'b1100000); end
    for (int e = 0; e < 5000; e++) begin
      step(0, 0);
      checks++;
      if (obs() !== 7'b1100000) begin errs++; $display("FAIL no_lock e=%0d got=%b exp=%b", e, obs(), 7'b1100000); end
    end
  endtask

  task automatic test_first_release();
    do_reset();
    for (int e = 0; e < 26; e++) begin
      step(1, 0);
      checks++;
      if (obs() !== exp_v()) begin errs++; $display("FAIL release_model e=%0d got=%b exp=%b", e, obs(), exp_v()); end
      if (e == 9 || e == 10) begin
        checks++;
        if (rst_core !== (e == 9)) begin errs++; $display("FAIL core_edge e=%0d got=%b exp=%b", e, rst_core, e == 9); end
      end
      if (e == 13 || e == 14) begin
        checks++;
        if ({rst_video, ready} !== {e == 13, e == 14}) begin errs++; $display("FAIL video_edge e=%0d got=%b%b", e, rst_video, ready); end
      end
      if (e >= 14) begin
        checks++;
        if (clk_en !== (e == 17 || e == 20 || e == 23)) begin errs++; $display("FAIL ce_edge e=%0d got=%b", e, clk_en); end
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int e = 0; e < 30; e++) begin
      step(!(e >= 6 && e <= 8), 0);
      checks++;
      if (obs() !== exp_v()) begin errs++; $display("FAIL glitch_model e=%0d got=%b exp=%b", e, obs(), exp_v()); end
      if (e == 18 || e == 19) begin
        checks++;
        if (rst_core !== (e == 18) || loss_cnt !== 0) begin errs++; $display("FAIL glitch_restart e=%0d core=%b loss=%0d", e, rst_core, loss_cnt); end
      end
    end
  endtask

  task automatic test_loss();
    do_reset();
    for (int e = 0; e < 60; e++) begin
      step(!(e >= 30 && e <= 34), 0);
      checks++;
      if (obs() !== exp_v()) begin errs++; $display("FAIL loss_model e=%0d got=%b exp=%b", e, obs(), exp_v()); end
      if (e == 31 || e == 32) begin
        checks++;
        if (obs() !== (e == 31 ? 7'b0010000 : 7'b1100101)) begin errs++; $display("FAIL loss_edge e=%0d got=%b", e, obs()); end
      end
      if (e == 44 || e == 45) begin
        checks++;
        if (rst_core !== (e == 44)) begin errs++; $display("FAIL relock_core e=%0d got=%b", e, rst_core); end
      end
      if (e == 48 || e == 49) begin
        checks++;
        if (ready !== (e == 49)) begin errs++; $display("FAIL relock_ready e=%0d got=%b", e, ready); end
      end
    end
  endtask

  task automatic test_soft();
    do_reset();
    for (int e = 0; e < 40; e++) begin
      step(1, e == 20);
      checks++;
      if (obs() !== exp_v()) begin errs++; $display("FAIL soft_model e=%0d got=%b exp=%b", e, obs(), exp_v()); end
      if (e == 20 || e == 27 || e == 28 || e == 31 || e == 32) begin
        checks++;
        if ({rst_core, ready, lock_lost, loss_cnt} !== {e < 28, e == 32, 1'b0, 2'd0}) begin
          errs++; $display("FAIL soft_timing e=%0d core=%b ready=%b lost=%b loss=%0d", e, rst_core, ready, lock_lost, loss_cnt);
        end
      end
    end
  endtask

  task automatic test_soft_and_loss();
    do_reset();
    for (int e = 0; e < 30; e++) begin
      step(e < 20, e == 22);
      checks++;
      if (obs() !== exp_v()) begin errs++; $display("FAIL both_model e=%0d got=%b exp=%b", e, obs(), exp_v()); end
      if (e == 22) begin
        checks++;
        if ({rst_core, lock_lost, loss_cnt} !== 4'b1101) begin errs++; $display("FAIL both_counted got=%b%b%0d", rst_core, lock_lost, loss_cnt); end
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 0; n < 5; n++)
      for (int e = 0; e < 23; e++) begin
        step(e < 20, 0);
        checks++;
        if (obs() !== exp_v()) begin errs++; $display("FAIL sat_model n=%0d e=%0d got=%b exp=%b", n, e, obs(), exp_v()); end
      end
    checks++;
    if ({lock_lost, loss_cnt} !== 3'b111) begin errs++; $display("FAIL sat_value got=%b%0d exp=1,3", lock_lost, loss_cnt); end
  endtask

  task automatic test_async_rst();
    for (int e = 0; e < 12; e++) step(1, 0);
    checks++;
    if ({rst_core, rst_video} !== 2'b01) begin errs++; $display("FAIL in_gap got=%b%b exp=01", rst_core, rst_video); end
    #2 rst = 1;
    #1;
    checks++;
    if (obs() !== 7'b1100000) begin errs++; $display("FAIL async_rst got=%b exp=%b", obs(), 7'b1100000); end
    k = 0; loss = 0; lost = 0; hist = '0;
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int seg = 0; seg < 200; seg++) begin
      logic l = 1'($urandom_range(0, 3) != 0);
      int len = $urandom_range(1, 30);
      for (int e = 0; e < len; e++) begin
        step(l, $urandom_range(0, 15) == 0);
        checks++;
        if (obs() !== exp_v()) begin errs++; $display("FAIL random_model seg=%0d got=%b exp=%b", seg, obs(), exp_v()); end
        checks++;
        if ((rst_core && !rst_video) || ready !== !rst_video || (clk_en && !ready)) begin
          errs++; $display("FAIL invariant seg=%0d got=%b", seg, obs());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_release();
    test_glitch();
    test_loss();
    test_soft();
    test_soft_and_loss();
    test_saturation();
    test_async_rst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
